// File: rtl/uart_rx_pacote_if.sv
// ---------------------------------------------------------------------------
// uart_rx_pacote_if
// Serial line plus decoded status packet of the game UART receiver.
//   rx              serial input, idle high
//   data            last complete packet {byte0, byte1}
//   valid           one-cycle pulse when data/fields update
//   estado          data[15:12]
//   macro           data[11:8]
//   micro           data[7:4]
//   resultado_macro data[3:2]
//   resultado_jogo  data[1:0]
//   frame_error     one-cycle pulse on bad stop bit or inter-byte timeout
// master: the receiver (consumes rx, produces the packet)
// slave : the line driver / packet consumer
// ---------------------------------------------------------------------------
interface uart_rx_pacote_if;
    logic        rx;
    logic [15:0] data;
    logic        valid;
    logic [3:0]  estado;
    logic [3:0]  macro;
    logic [3:0]  micro;
    logic [1:0]  resultado_macro;
    logic [1:0]  resultado_jogo;
    logic        frame_error;

    modport master (
        input  rx,
        output data, valid, estado, macro, micro,
               resultado_macro, resultado_jogo, frame_error
    );

    modport slave (
        output rx,
        input  data, valid, estado, macro, micro,
               resultado_macro, resultado_jogo, frame_error
    );
endinterface

// File: rtl/uart_rx_pacote.sv
// ---------------------------------------------------------------------------
// uart_rx_pacote
// Receives the game's 16-bit status packet as two 8N1 bytes (high byte
// first) and splits it into its status fields.
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   bus    uart_rx_pacote_if.master: rx in; data, fields, valid,
//          frame_error out
// ---------------------------------------------------------------------------
module uart_rx_pacote #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic             clock,
    input  logic             reset,
    uart_rx_pacote_if.master bus
);
    localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_M1  = GAP_W'(GAP_LIMIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              byte_idx;
    logic [7:0]        high_byte;
    logic [GAP_W-1:0]  gap_cnt;
    logic [15:0]       data_r;
    logic              valid_r;
    logic              frame_error_r;

    // rx is asynchronous to clock; idle level is high so reset to 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            byte_idx      <= 1'b0;
            high_byte     <= '0;
            gap_cnt       <= '0;
            data_r        <= '0;
            valid_r       <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            valid_r       <= 1'b0;
            frame_error_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Glitch: silently resume waiting; a pending high
                            // byte keeps its timeout window alive via GAP.
                            state   <= byte_idx ? GAP : IDLE;
                            gap_cnt <= '0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    // Sampling one full bit after mid-start lands mid-bit
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_error_r <= 1'b1;
                            byte_idx      <= 1'b0;
                            state         <= IDLE;
                        end else if (!byte_idx) begin
                            high_byte <= shift;
                            byte_idx  <= 1'b1;
                            gap_cnt   <= '0;
                            state     <= GAP;
                        end else begin
                            data_r   <= {high_byte, shift};
                            valid_r  <= 1'b1;
                            byte_idx <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end else if (gap_cnt == GAP_M1) begin
                        frame_error_r <= 1'b1;
                        byte_idx      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data            = data_r;
    assign bus.valid           = valid_r;
    assign bus.frame_error     = frame_error_r;
    assign bus.estado          = data_r[15:12];
    assign bus.macro           = data_r[11:8];
    assign bus.micro           = data_r[7:4];
    assign bus.resultado_macro = data_r[3:2];
    assign bus.resultado_jogo  = data_r[1:0];
endmodule

// File: tb/tb_uart_rx_pacote.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pacote
// Self-checking bench for uart_rx_pacote with a packet scoreboard.
// ---------------------------------------------------------------------------
module tb_uart_rx_pacote;
    localparam int CPB = 8;
    localparam int TOB = 20;

    logic clock;
    logic reset;

    uart_rx_pacote_if bus ();

    uart_rx_pacote #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_valid   = 0;
    int n_fe      = 0;
    int n_overlap = 0;
    int n_pushed  = 0;
    logic [15:0] sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: pop expected packet on every valid pulse
    always @(negedge clock) begin
        if (reset) begin
            if (bus.valid && bus.frame_error) n_overlap++;
            if (bus.frame_error) n_fe++;
            if (bus.valid) begin
                n_valid++;
                if (sb.size() != 0) begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    check("sb_data",   {16'h0, bus.data},          {16'h0, e});
                    check("sb_estado", {28'h0, bus.estado},        {28'h0, e[15:12]});
                    check("sb_macro",  {28'h0, bus.macro},         {28'h0, e[11:8]});
                    check("sb_micro",  {28'h0, bus.micro},         {28'h0, e[7:4]});
                    check("sb_rmacro", {30'h0, bus.resultado_macro}, {30'h0, e[3:2]});
                    check("sb_rjogo",  {30'h0, bus.resultado_jogo},  {30'h0, e[1:0]});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            wait_clks(CPB);
        end
        bus.rx = stop_bit;
        wait_clks(CPB);
        bus.rx = 1'b1;
    endtask

    task automatic send_packet(input logic [15:0] w);
        sb.push_back(w);
        n_pushed++;
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    initial begin
        int fe0;
        int v0;
        logic [15:0] w;

        reset  = 1'b0;
        bus.rx = 1'b1;
        wait_clks(3);
        check("rst_data",  {16'h0, bus.data}, 32'h0);
        check("rst_valid", {31'h0, bus.valid}, 32'h0);
        check("rst_fe",    {31'h0, bus.frame_error}, 32'h0);
        reset = 1'b1;
        wait_clks(2 * CPB);

        // Ideal packet
        send_packet(16'hA5C3);
        wait_clks(2);
        check("a5c3_data",   {16'h0, bus.data}, 32'hA5C3);
        check("a5c3_estado", {28'h0, bus.estado}, 32'hA);
        check("a5c3_macro",  {28'h0, bus.macro}, 32'h5);
        check("a5c3_micro",  {28'h0, bus.micro}, 32'hC);
        check("a5c3_rmacro", {30'h0, bus.resultado_macro}, 32'h0);
        check("a5c3_rjogo",  {30'h0, bus.resultado_jogo}, 32'h3);
        check("a5c3_no_fe",  n_fe, 0);

        // Short glitch on rx
        fe0 = n_fe;
        v0  = n_valid;
        bus.rx = 1'b0;
        wait_clks(3);
        bus.rx = 1'b1;
        wait_clks(3 * CPB);
        check("glitch_fe",    n_fe, fe0);
        check("glitch_valid", n_valid, v0);
        send_packet(16'h1234);
        wait_clks(2);
        check("after_glitch_data", {16'h0, bus.data}, 32'h1234);

        // Bad stop bit on the first byte
        fe0 = n_fe;
        v0  = n_valid;
        send_byte(8'h3C, 1'b0);
        wait_clks(3 * CPB);
        check("bad_stop_fe",    n_fe, fe0 + 1);
        check("bad_stop_valid", n_valid, v0);
        check("bad_stop_data",  {16'h0, bus.data}, 32'h1234);
        send_packet(16'h0F0F);
        wait_clks(2);
        check("after_bad_stop_data", {16'h0, bus.data}, 32'h0F0F);

        // Inter-byte timeout
        fe0 = n_fe;
        send_byte(8'h55, 1'b1);
        wait_clks(25 * CPB);
        check("timeout_fe",   n_fe, fe0 + 1);
        check("timeout_data", {16'h0, bus.data}, 32'h0F0F);
        send_packet(16'h8000);
        wait_clks(2);
        check("after_timeout_data",   {16'h0, bus.data}, 32'h8000);
        check("after_timeout_estado", {28'h0, bus.estado}, 32'h8);

        // Reset during bit 4 of the second byte
        fe0 = n_fe;
        send_byte(8'h12, 1'b1);
        w = 16'h0034;
        bus.rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = w[i];
            wait_clks(CPB);
        end
        bus.rx = w[4];
        wait_clks(CPB / 2);
        reset = 1'b0;
        #1;
        check("midrst_data",   {16'h0, bus.data}, 32'h0);
        check("midrst_valid",  {31'h0, bus.valid}, 32'h0);
        check("midrst_fe",     {31'h0, bus.frame_error}, 32'h0);
        check("midrst_estado", {28'h0, bus.estado}, 32'h0);
        check("midrst_rjogo",  {30'h0, bus.resultado_jogo}, 32'h0);
        bus.rx = 1'b1;
        wait_clks(4);
        reset = 1'b1;
        wait_clks(25 * CPB);
        check("midrst_no_fe", n_fe, fe0);
        send_packet(16'hFFFF);
        wait_clks(2);
        check("ffff_data",   {16'h0, bus.data}, 32'hFFFF);
        check("ffff_estado", {28'h0, bus.estado}, 32'hF);
        check("ffff_macro",  {28'h0, bus.macro}, 32'hF);
        check("ffff_micro",  {28'h0, bus.micro}, 32'hF);
        check("ffff_rmacro", {30'h0, bus.resultado_macro}, 32'h3);
        check("ffff_rjogo",  {30'h0, bus.resultado_jogo}, 32'h3);

        // Back-to-back packets, zero idle between bytes
        v0 = n_valid;
        send_packet(16'h1357);
        send_packet(16'h2468);
        send_packet(16'h9ABC);
        wait_clks(2);
        check("b2b_count", n_valid, v0 + 3);

        // A few random words
        for (int k = 0; k < 4; k++) begin
            w = 16'($urandom_range(0, 16'hFFFF));
            send_packet(w);
        end

        for (int k = 0; k < 200 && sb.size() != 0; k++) wait_clks(1);
        check("sb_drain",   sb.size(), 0);
        check("valid_total", n_valid, n_pushed);
        check("fe_total",    n_fe, 2);
        check("overlap",     n_overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_pacote.md
Name: uart_rx_pacote

Overview:
- Serial receiver that sits directly downstream of the game's UART transmitter and consumes its `s_out` line.
- Recovers the 16-bit status packet, sent as two 8N1 bytes, high byte first.
- Splits the packet into estado, macro, micro, resultado_macro and resultado_jogo fields.
- Uses: loopback verification of the transmit path, and a second board / debug monitor that mirrors game state.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); minimum 4.
- TIMEOUT_BITS, 20, bit-times allowed between the first byte's stop sample and the second byte's start edge.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high; asynchronous to clock.
- data  out  16  last complete packet, {byte0, byte1}.
- valid  out  1  one-cycle pulse when data and fields update.
- estado  out  4  data[15:12].
- macro  out  4  data[11:8].
- micro  out  4  data[7:4].
- resultado_macro  out  2  data[3:2].
- resultado_jogo  out  2  data[1:0].
- frame_error  out  1  one-cycle pulse on bad stop bit or inter-byte timeout.

Behaviour:
- Reset: asserting reset (low) asynchronously clears all of the following.
  - data, fields, valid, frame_error to 0.
  - FSM to IDLE; byte index to 0.
  - Synchronizer flops to 1.
- Input path: rx passes through a 2-FF synchronizer. All sampling uses rx_s, the second flop.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, STOP, GAP.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - At cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s==1: glitch -> back to IDLE (GAP if byte index is 1); no error reported.
  - rx_s==0 -> DATA, cnt=0, bit=0.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles (mid-bit), LSB first, into an 8-bit shift register.
  - After bit 7 -> STOP.
- STOP:
  - Sample at mid stop bit.
  - rx_s==0: pulse frame_error, discard any partial packet, byte index=0 -> IDLE.
  - rx_s==1 with byte index 0: store the byte as the high byte, byte index=1 -> GAP.
  - rx_s==1 with byte index 1: on the next clock edge, load data={high, byte}, update fields, pulse valid for exactly 1 cycle. Byte index=0 -> IDLE.
- GAP:
  - Behaves like IDLE but runs a timeout counter from 0.
  - rx_s==0 -> START.
  - Counter reaches TIMEOUT_BITS*CLKS_PER_BIT: pulse frame_error, discard the high byte, byte index=0 -> IDLE.
- Latency: valid rises 1 clock after the mid-stop sample of the second byte. It is always low otherwise; valid and frame_error are never high together.
- Holding: data and fields hold their value until the next valid; a frame error does not clear them.
- Continuous receive: no busy or backpressure. A new start edge may arrive half a bit after the stop sample and must be caught.
- Reset mid-byte: the partial byte and any stored high byte are lost; no pulses are generated.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_BITS=20 in simulation):
- Send bytes 0xA5, 0xC3 with ideal timing -> one valid pulse.
  - data=0xA5C3, estado=0xA, macro=0x5, micro=0xC, resultado_macro=0, resultado_jogo=3.
  - frame_error never high.
- rx low for 3 clocks, then high -> no state leaves IDLE beyond START, no valid, no frame_error; a following 0x1234 packet decodes correctly.
- First byte with stop bit=0 -> one frame_error pulse, no valid, data unchanged. Next good packet 0x0F0F -> valid, data=0x0F0F.
- Send 0x55, then idle 25 bit-times -> frame_error pulse. Next packet 0x8000 -> data=0x8000, estado=8.
- Assert reset during bit 4 of the second byte -> all outputs 0 immediately. After release, packet 0xFFFF -> data=0xFFFF, all fields at maximum.
- Three packets back-to-back, zero idle between bytes -> exactly three valid pulses with correct values. Loopback from the game's UART transmitter yields data equal to its 16-bit input word.
